// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: selects one of NSRC packed sources per beat and registers it
// behind a two-entry (output + skid) valid/ready stage with a registered in_ready.
module mux_pipe_stage #(
  parameter int WIDTH = 5,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSRC*WIDTH-1:0]   src,
  input  logic [SELW-1:0]         sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pick_data, skid_data;
  logic             pick_err, skid_err;
  logic             in_fire, out_fire;
  logic             load_out, load_skid, move_skid;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Source selection; out-of-range select yields zero data with the error flag.
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        pick_data = src[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // Next-state and entry load controls; flush overrides every transfer.
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_out  = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_out  = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = TWO;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            move_skid = 1'b1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register with registered handshake outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Data/error storage; left untouched by flush so only the valid state clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      sel_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_out) begin
        result  <= pick_data;
        sel_err <= pick_err;
      end else if (move_skid) begin
        result  <= skid_data;
        sel_err <= skid_err;
      end
      if (load_skid) begin
        skid_data <= pick_data;
        skid_err  <= pick_err;
      end
    end
  end

endmodule

// File: doc/mux_pipe_stage.md
MUX_PIPE_STAGE -- requirements
Module: mux_pipe_stage

Interface
REQ-001 Parameter WIDTH, default 5, bit width of each source and of result.
REQ-002 Parameter NSRC, default 4, number of selectable sources (2..16).
REQ-003 Parameter SELW, default 2, select width; SHALL satisfy 2**SELW >= NSRC.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat; driven from a register.
REQ-009 src  input  NSRC*WIDTH  packed sources; source k = src[k*WIDTH +: WIDTH].
REQ-010 sel  input  SELW  source index for the beat.
REQ-011 out_valid  output  1  result holds a valid beat.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 result  output  WIDTH  selected source, registered.
REQ-014 sel_err  output  1  beat's sel was >= NSRC; qualified by out_valid.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Stage SHALL hold two entries: output register (OUT) and skid register (SKID), each storing {data, err, valid}.
REQ-017 Selected data SHALL be src[sel*WIDTH +: WIDTH] when sel < NSRC; otherwise 0 with err=1.
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N appears on result/out_valid after edge N when OUT is empty or draining.
REQ-019 Beats SHALL leave in acceptance order; none duplicated or lost except by flush.
REQ-020 On input transfer with OUT empty, or OUT transferring and SKID empty, the beat SHALL load OUT.
REQ-021 On input transfer with OUT valid and not transferring, the beat SHALL load SKID.
REQ-022 On output transfer with SKID valid, SKID SHALL move to OUT and SKID SHALL become empty; a simultaneous input beat is impossible because in_ready=0 whenever SKID is valid.
REQ-023 in_ready SHALL be registered as !SKID.valid of the next state; no combinational path from out_ready to in_ready.
REQ-024 States: EMPTY (OUT, SKID empty), ONE (OUT full), TWO (both full); in_ready=1 in EMPTY/ONE, 0 in TWO.
REQ-025 Transitions: EMPTY->ONE on input; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE->ONE on both; TWO->ONE on output; TWO holds otherwise.
REQ-026 result and sel_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 flush SHALL empty OUT and SKID at the edge, discard any input beat of that cycle, and yield in_ready=1, out_valid=0 next cycle.
REQ-028 flush SHALL take priority over all transfers in the same cycle.
REQ-029 result and sel_err SHALL not change when a flush empties the stage (valid bits only cleared).

Reset
REQ-030 While rst=1: out_valid=0, in_ready=1, result=0, sel_err=0, SKID.valid=0, state EMPTY, asynchronously.
REQ-031 First transfer SHALL be possible at the first rising edge after rst deasserts.
REQ-032 rst mid-operation SHALL discard both entries without emitting them.

Verification
REQ-033 Defaults, src={4'd?:k*3+1}, sel=2, in_valid=1, out_ready=1 one cycle -> next cycle out_valid=1, result=7, sel_err=0.
REQ-034 out_ready=0, send beats sel=0 (1) and sel=1 (4) -> in_ready=0 after second; out_ready=1 -> results 1 then 4 on consecutive cycles, in_ready=1 again.
REQ-035 NSRC=3, sel=3 -> result=0, sel_err=1, out_valid=1.
REQ-036 Stage in TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no beat emitted later.
REQ-037 Continuous in_valid=1, out_ready toggling 1/0 for 20 cycles with incrementing sel mod NSRC -> output sequence equals accepted sequence, no gaps/duplicates.
REQ-038 rst asserted mid-stream with two beats held -> out_valid=0, in_ready=1, result=0 immediately, before next clk edge.
